// File: rtl/snake_dir_ctrl.sv
// rtl/snake_dir_ctrl.sv - switch sync/debounce, priority + reversal filter, tick-aligned direction commit
module snake_dir_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_WIDTH       = 20
) (
    input  logic       CLK,
    input  logic       RST_BTN,
    input  logic [3:0] sw,
    input  logic       move_clk,
    output logic [3:0] o_sw,
    output logic [1:0] o_dir,
    output logic       o_turn,
    output logic [3:0] o_deb
);

    localparam logic [CNT_WIDTH-1:0] DEB_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic [3:0]           sync1_q, sync1_d;
    logic [3:0]           sync2_q, sync2_d;
    logic [3:0]           deb_q, deb_d;
    logic [CNT_WIDTH-1:0] cnt_q [4];
    logic [CNT_WIDTH-1:0] cnt_d [4];
    logic [1:0]           pending_q, pending_d;
    logic [1:0]           dir_q, dir_d;
    logic [3:0]           onehot_q, onehot_d;
    logic                 turn_q, turn_d;

    logic                 cand_valid;
    logic [1:0]           cand;

    always_comb begin
        sync1_d = sw;
        sync2_d = sync1_q;
    end

    // A level is accepted only after DEBOUNCE_CYCLES consecutive samples disagreeing with it.
    always_comb begin
        deb_d = deb_q;
        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync2_q[i] == deb_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == DEB_LAST) begin
                deb_d[i] = sync2_q[i];
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
            end
        end
    end

    always_comb begin
        cand_valid = 1'b1;
        cand       = 2'b00;
        if (deb_q[3]) begin
            cand = 2'b11;
        end else if (deb_q[2]) begin
            cand = 2'b10;
        end else if (deb_q[1]) begin
            cand = 2'b01;
        end else if (deb_q[0]) begin
            cand = 2'b00;
        end else begin
            cand_valid = 1'b0;
        end
    end

    // Opposite directions differ only in bit 0 (right/left, down/up).
    always_comb begin
        pending_d = pending_q;
        if (cand_valid && (cand != (dir_q ^ 2'b01))) begin
            pending_d = cand;
        end
    end

    always_comb begin
        dir_d    = dir_q;
        onehot_d = onehot_q;
        turn_d   = 1'b0;
        if (move_clk) begin
            dir_d    = pending_q;
            onehot_d = 4'b0001 << pending_q;
            turn_d   = (pending_q != dir_q);
        end
    end

    always_ff @(posedge CLK or negedge RST_BTN) begin
        if (!RST_BTN) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            deb_q     <= '0;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= '0;
            end
            pending_q <= 2'b00;
            dir_q     <= 2'b00;
            onehot_q  <= 4'b0001;
            turn_q    <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            deb_q     <= deb_d;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            pending_q <= pending_d;
            dir_q     <= dir_d;
            onehot_q  <= onehot_d;
            turn_q    <= turn_d;
        end
    end

    assign o_sw   = onehot_q;
    assign o_dir  = dir_q;
    assign o_turn = turn_q;
    assign o_deb  = deb_q;

endmodule

// File: tb/tb_snake_dir_ctrl.sv
// tb/tb_snake_dir_ctrl.sv - directed vector bench for snake_dir_ctrl
module tb_snake_dir_ctrl;

    logic       CLK = 1'b0;
    logic       RST_BTN = 1'b0;
    logic [3:0] sw = 4'b0000;
    logic       move_clk = 1'b0;
    logic [3:0] o_sw;
    logic [1:0] o_dir;
    logic       o_turn;
    logic [3:0] o_deb;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic       rst_n;
        logic [3:0] sw;
        logic       mv;
        logic [3:0] esw;
        logic [1:0] edir;
        logic       eturn;
        logic [3:0] edeb;
    } vec_t;

    vec_t vecs[$];

    snake_dir_ctrl #(.DEBOUNCE_CYCLES(4), .CNT_WIDTH(3)) dut (
        .CLK      (CLK),
        .RST_BTN  (RST_BTN),
        .sw       (sw),
        .move_clk (move_clk),
        .o_sw     (o_sw),
        .o_dir    (o_dir),
        .o_turn   (o_turn),
        .o_deb    (o_deb)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [3:0] esw, input logic [1:0] edir,
                             input logic eturn, input logic [3:0] edeb);
        check({tag, " o_sw"},   o_sw,   esw);
        check({tag, " o_dir"},  {2'b00, o_dir},  {2'b00, edir});
        check({tag, " o_turn"}, {3'b000, o_turn}, {3'b000, eturn});
        check({tag, " o_deb"},  o_deb,  edeb);
    endtask

    task automatic add_n(input int n, input logic rst_n, input logic [3:0] s, input logic mv,
                         input logic [3:0] esw, input logic [1:0] edir, input logic eturn,
                         input logic [3:0] edeb);
        vec_t v;
        v.rst_n = rst_n; v.sw = s; v.mv = mv;
        v.esw = esw; v.edir = edir; v.eturn = eturn; v.edeb = edeb;
        for (int k = 0; k < n; k++) vecs.push_back(v);
    endtask

    task automatic cycle(input logic [3:0] s, input logic mv);
        sw = s;
        move_clk = mv;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        // Reset and idle tick
        add_n(1, 0, 4'b0000, 0, 4'b0001, 2'b00, 0, 4'b0000);
        add_n(1, 1, 4'b0000, 0, 4'b0001, 2'b00, 0, 4'b0000);
        add_n(1, 1, 4'b0000, 1, 4'b0001, 2'b00, 0, 4'b0000);
        add_n(1, 1, 4'b0000, 0, 4'b0001, 2'b00, 0, 4'b0000);
        // Up: debounced on the 6th edge, pending one edge later, then commit
        add_n(5, 1, 4'b1000, 0, 4'b0001, 2'b00, 0, 4'b0000);
        add_n(2, 1, 4'b1000, 0, 4'b0001, 2'b00, 0, 4'b1000);
        add_n(1, 1, 4'b1000, 1, 4'b1000, 2'b11, 1, 4'b1000);
        add_n(1, 1, 4'b1000, 0, 4'b1000, 2'b11, 0, 4'b1000);
        // Reset back to right
        add_n(1, 0, 4'b0000, 0, 4'b0001, 2'b00, 0, 4'b0000);
        add_n(1, 1, 4'b0000, 0, 4'b0001, 2'b00, 0, 4'b0000);
        // Left from right is rejected
        add_n(5, 1, 4'b0010, 0, 4'b0001, 2'b00, 0, 4'b0000);
        add_n(2, 1, 4'b0010, 0, 4'b0001, 2'b00, 0, 4'b0010);
        add_n(1, 1, 4'b0010, 1, 4'b0001, 2'b00, 0, 4'b0010);
        // Down added with left held: down wins
        add_n(5, 1, 4'b0110, 0, 4'b0001, 2'b00, 0, 4'b0010);
        add_n(2, 1, 4'b0110, 0, 4'b0001, 2'b00, 0, 4'b0110);
        add_n(1, 1, 4'b0110, 1, 4'b0100, 2'b10, 1, 4'b0110);
        // Release down: held left becomes legal
        add_n(5, 1, 4'b0010, 0, 4'b0100, 2'b10, 0, 4'b0110);
        add_n(2, 1, 4'b0010, 0, 4'b0100, 2'b10, 0, 4'b0010);
        add_n(1, 1, 4'b0010, 1, 4'b0010, 2'b01, 1, 4'b0010);
        add_n(1, 1, 4'b0010, 0, 4'b0010, 2'b01, 0, 4'b0010);
        // Reset, then left+down with tick on the pending-update edge
        add_n(1, 0, 4'b0000, 0, 4'b0001, 2'b00, 0, 4'b0000);
        add_n(1, 1, 4'b0000, 0, 4'b0001, 2'b00, 0, 4'b0000);
        add_n(5, 1, 4'b0110, 0, 4'b0001, 2'b00, 0, 4'b0000);
        add_n(1, 1, 4'b0110, 0, 4'b0001, 2'b00, 0, 4'b0110);
        add_n(1, 1, 4'b0110, 1, 4'b0001, 2'b00, 0, 4'b0110);
        add_n(1, 1, 4'b0110, 0, 4'b0001, 2'b00, 0, 4'b0110);
        add_n(1, 1, 4'b0110, 1, 4'b0100, 2'b10, 1, 4'b0110);
        add_n(1, 1, 4'b0110, 0, 4'b0100, 2'b10, 0, 4'b0110);

        #1;
        foreach (vecs[i]) begin
            RST_BTN = vecs[i].rst_n;
            cycle(vecs[i].sw, vecs[i].mv);
            check_all($sformatf("v%0d", i), vecs[i].esw, vecs[i].edir, vecs[i].eturn, vecs[i].edeb);
        end

        // Bouncing down switch never reaches the debounce threshold
        RST_BTN = 1'b0;
        cycle(4'b0000, 0);
        RST_BTN = 1'b1;
        cycle(4'b0000, 0);
        for (int c = 0; c < 20; c++) begin
            cycle(((c % 4) < 2) ? 4'b0100 : 4'b0000, 0);
            check($sformatf("glitch%0d o_deb", c), o_deb, 4'b0000);
        end
        repeat (5) cycle(4'b0000, 0);
        check("glitch tail o_deb", o_deb, 4'b0000);
        cycle(4'b0000, 1);
        check_all("glitch tick", 4'b0001, 2'b00, 0, 4'b0000);
        cycle(4'b0000, 0);

        // Async reset with pending=11, turn high and sw[2] mid-debounce
        repeat (7) cycle(4'b1000, 0);
        cycle(4'b1100, 1);
        check_all("pre-reset", 4'b1000, 2'b11, 1, 4'b1000);
        move_clk = 1'b0;
        #3 RST_BTN = 1'b0;
        #1;
        check_all("async reset", 4'b0001, 2'b00, 0, 4'b0000);
        cycle(4'b1100, 0);
        check_all("reset held", 4'b0001, 2'b00, 0, 4'b0000);
        RST_BTN = 1'b1;
        repeat (3) cycle(4'b0000, 0);
        cycle(4'b0000, 1);
        check_all("post-reset tick", 4'b0001, 2'b00, 0, 4'b0000);
        cycle(4'b0000, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
